// File: rtl/iob_cache_axi_mem_slave_if.sv
// AXI4 bus bundle between the cache back-end (master) and the test memory (slave).
// Signal names keep the _i/_o suffix as seen from the memory side.
interface iob_cache_axi_mem_slave_if #(
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8
) ();
  // write address channel
  logic [AXI_ID_W-1:0]     axi_awid_i;
  logic [AXI_ADDR_W-1:0]   axi_awaddr_i;
  logic [AXI_LEN_W-1:0]    axi_awlen_i;
  logic                    axi_awvalid_i;
  logic                    axi_awready_o;
  // write data channel
  logic [AXI_DATA_W-1:0]   axi_wdata_i;
  logic [AXI_DATA_W/8-1:0] axi_wstrb_i;
  logic                    axi_wlast_i;
  logic                    axi_wvalid_i;
  logic                    axi_wready_o;
  // write response channel
  logic [AXI_ID_W-1:0]     axi_bid_o;
  logic [1:0]              axi_bresp_o;
  logic                    axi_bvalid_o;
  logic                    axi_bready_i;
  // read address channel
  logic [AXI_ID_W-1:0]     axi_arid_i;
  logic [AXI_ADDR_W-1:0]   axi_araddr_i;
  logic [AXI_LEN_W-1:0]    axi_arlen_i;
  logic                    axi_arvalid_i;
  logic                    axi_arready_o;
  // read data channel
  logic [AXI_ID_W-1:0]     axi_rid_o;
  logic [AXI_DATA_W-1:0]   axi_rdata_o;
  logic [1:0]              axi_rresp_o;
  logic                    axi_rlast_o;
  logic                    axi_rvalid_o;
  logic                    axi_rready_i;

  modport slave (
    input  axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awvalid_i,
    output axi_awready_o,
    input  axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i,
    output axi_wready_o,
    output axi_bid_o, axi_bresp_o, axi_bvalid_o,
    input  axi_bready_i,
    input  axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arvalid_i,
    output axi_arready_o,
    output axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o,
    input  axi_rready_i
  );

  modport master (
    output axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awvalid_i,
    input  axi_awready_o,
    output axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i,
    input  axi_wready_o,
    input  axi_bid_o, axi_bresp_o, axi_bvalid_o,
    output axi_bready_i,
    output axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arvalid_i,
    input  axi_arready_o,
    input  axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o,
    output axi_rready_i
  );
endinterface

// File: rtl/iob_cache_axi_mem_slave.sv
// AXI4 slave memory behind iob_cache: INCR bursts served from a word-wide RAM.
// Read and write channels are independent FSMs sharing one dual-port array;
// all handshake outputs are registered.
module iob_cache_axi_mem_slave #(
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8,
  parameter int MEM_ADDR_W = 10
) (
  input logic                      clk_i,
  input logic                      rstn_i,
  iob_cache_axi_mem_slave_if.slave axi
);
  localparam int NBYTES   = AXI_DATA_W / 8;
  localparam int NBYTES_W = $clog2(NBYTES);
  localparam logic [MEM_ADDR_W-1:0] ADDR_ONE = MEM_ADDR_W'(1);
  localparam logic [AXI_LEN_W-1:0]  LEN_ONE  = AXI_LEN_W'(1);

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rState_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;

  logic [AXI_DATA_W-1:0] r_mem [2**MEM_ADDR_W];

  // read channel state
  rState_t               r_rState;
  logic                  r_arReady;
  logic                  r_rValid;
  logic                  r_rLast;
  logic [AXI_ID_W-1:0]   r_arId;
  logic [AXI_ID_W-1:0]   r_rId;
  logic [AXI_DATA_W-1:0] r_rData;
  logic [MEM_ADDR_W-1:0] r_rAddr;
  logic [AXI_LEN_W-1:0]  r_rCnt;

  // write channel state
  wState_t               r_wState;
  logic                  r_awReady;
  logic                  r_wReady;
  logic                  r_bValid;
  logic [1:0]            r_bResp;
  logic [AXI_ID_W-1:0]   r_awId;
  logic [AXI_ID_W-1:0]   r_bId;
  logic [MEM_ADDR_W-1:0] r_wAddr;
  logic [AXI_LEN_W-1:0]  r_wCnt;

  logic                    w_wrEn;
  logic [2*AXI_ADDR_W-1:0] w_unusedAddr;

  // Only the word-index bits of the byte addresses matter; the rest are ignored.
  assign w_unusedAddr = {axi.axi_awaddr_i, axi.axi_araddr_i};

  // A W beat is consumed whenever the write FSM sits in W_DATA with wvalid high.
  assign w_wrEn = rstn_i && (r_wState == W_DATA) && axi.axi_wvalid_i;

  // RAM write port: byte-granular update under wstrb, never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (w_wrEn) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (axi.axi_wstrb_i[b]) begin
          r_mem[r_wAddr][b*8 +: 8] <= axi.axi_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Read FSM: accept AR, fetch one word per beat into rdata, hold it until rready.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_rState  <= R_IDLE;
      r_arReady <= 1'b0;
      r_rValid  <= 1'b0;
      r_rLast   <= 1'b0;
      r_arId    <= '0;
      r_rId     <= '0;
      r_rData   <= '0;
      r_rAddr   <= '0;
      r_rCnt    <= '0;
    end else begin
      case (r_rState)
        R_IDLE: begin
          if (r_arReady && axi.axi_arvalid_i) begin
            r_arId    <= axi.axi_arid_i;
            r_rAddr   <= axi.axi_araddr_i[NBYTES_W +: MEM_ADDR_W];
            r_rCnt    <= axi.axi_arlen_i;
            r_arReady <= 1'b0;
            r_rState  <= R_FETCH;
          end else begin
            r_arReady <= 1'b1;
          end
        end
        R_FETCH: begin
          r_rData  <= r_mem[r_rAddr];
          r_rValid <= 1'b1;
          r_rLast  <= (r_rCnt == '0);
          r_rId    <= r_arId;
          r_rState <= R_DATA;
        end
        R_DATA: begin
          if (axi.axi_rready_i) begin
            r_rValid <= 1'b0;
            r_rLast  <= 1'b0;
            if (r_rLast) begin
              r_arReady <= 1'b1;
              r_rState  <= R_IDLE;
            end else begin
              r_rCnt   <= r_rCnt - LEN_ONE;
              r_rAddr  <= r_rAddr + ADDR_ONE;
              r_rState <= R_FETCH;
            end
          end
        end
        default: r_rState <= R_IDLE;
      endcase
    end
  end

  // Write FSM: accept AW, absorb W beats until wlast or the beat count runs out, then respond.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wState  <= W_IDLE;
      r_awReady <= 1'b0;
      r_wReady  <= 1'b0;
      r_bValid  <= 1'b0;
      r_bResp   <= 2'b00;
      r_awId    <= '0;
      r_bId     <= '0;
      r_wAddr   <= '0;
      r_wCnt    <= '0;
    end else begin
      case (r_wState)
        W_IDLE: begin
          if (r_awReady && axi.axi_awvalid_i) begin
            r_awId    <= axi.axi_awid_i;
            r_wAddr   <= axi.axi_awaddr_i[NBYTES_W +: MEM_ADDR_W];
            r_wCnt    <= axi.axi_awlen_i;
            r_awReady <= 1'b0;
            r_wReady  <= 1'b1;
            r_wState  <= W_DATA;
          end else begin
            r_awReady <= 1'b1;
          end
        end
        W_DATA: begin
          if (axi.axi_wvalid_i) begin
            r_wAddr <= r_wAddr + ADDR_ONE;
            r_wCnt  <= r_wCnt - LEN_ONE;
            if (axi.axi_wlast_i || (r_wCnt == '0)) begin
              // A wlast that disagrees with the announced length is flagged SLVERR.
              r_bResp  <= (axi.axi_wlast_i && (r_wCnt == '0)) ? 2'b00 : 2'b10;
              r_bId    <= r_awId;
              r_bValid <= 1'b1;
              r_wReady <= 1'b0;
              r_wState <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi.axi_bready_i) begin
            r_bValid  <= 1'b0;
            r_awReady <= 1'b1;
            r_wState  <= W_IDLE;
          end
        end
        default: r_wState <= W_IDLE;
      endcase
    end
  end

  assign axi.axi_awready_o = r_awReady;
  assign axi.axi_wready_o  = r_wReady;
  assign axi.axi_bid_o     = r_bId;
  assign axi.axi_bresp_o   = r_bResp;
  assign axi.axi_bvalid_o  = r_bValid;
  assign axi.axi_arready_o = r_arReady;
  assign axi.axi_rid_o     = r_rId;
  assign axi.axi_rdata_o   = r_rData;
  assign axi.axi_rresp_o   = 2'b00;
  assign axi.axi_rlast_o   = r_rLast;
  assign axi.axi_rvalid_o  = r_rValid;
endmodule

// File: tb/tb_iob_cache_axi_mem_slave.sv
// Testbench for iob_cache_axi_mem_slave: directed scenarios plus randomized bursts
// checked against a word-array model of the memory.
module tb_iob_cache_axi_mem_slave;
  localparam int TMO = 200;

  logic clk;
  logic rstn;

  iob_cache_axi_mem_slave_if #(.AXI_ADDR_W(24), .AXI_DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)) axi ();

  iob_cache_axi_mem_slave #(
    .AXI_ADDR_W(24), .AXI_DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8), .MEM_ADDR_W(10)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .axi   (axi.slave)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nPass  = 0;
  int nTotal = 0;

  logic [31:0] model [1024];
  logic [31:0] wData [256];
  logic [3:0]  wStrb [256];
  logic [31:0] rData [256];
  logic        rLastQ [256];
  logic [0:0]  rIdQ [256];
  logic [1:0]  rRespQ [256];

  function automatic int wordOf(input logic [23:0] addr);
    return (int'(addr) / 4) % 1024;
  endfunction

  function automatic void modelWrite(input int word, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) model[word % 1024][b*8 +: 8] = d[b*8 +: 8];
    end
  endfunction

  // Drive one AW + nBeats W beats (wlast on the last one unless noLast) and collect B.
  task automatic axiWrite(input logic [0:0] id, input logic [23:0] addr, input logic [7:0] len,
                          input int nBeats, input bit wEarly, input bit noLast,
                          output logic [1:0] resp, output logic [0:0] bid, output int bWait,
                          output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    axi.axi_awid_i    = id;
    axi.axi_awaddr_i  = addr;
    axi.axi_awlen_i   = len;
    axi.axi_awvalid_i = 1'b1;
    if (wEarly) begin
      axi.axi_wvalid_i = 1'b1;
      axi.axi_wdata_i  = wData[0];
      axi.axi_wstrb_i  = wStrb[0];
      axi.axi_wlast_i  = !noLast && (nBeats == 1);
    end
    n = 0;
    while (axi.axi_awready_o !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) ok = 1'b0;
    @(negedge clk);
    axi.axi_awvalid_i = 1'b0;
    for (int i = 0; i < nBeats; i++) begin
      axi.axi_wvalid_i = 1'b1;
      axi.axi_wdata_i  = wData[i];
      axi.axi_wstrb_i  = wStrb[i];
      axi.axi_wlast_i  = !noLast && (i == nBeats - 1);
      n = 0;
      while (axi.axi_wready_o !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) ok = 1'b0;
      @(negedge clk);
    end
    axi.axi_wvalid_i = 1'b0;
    axi.axi_wlast_i  = 1'b0;
    axi.axi_bready_i = 1'b1;
    n = 0;
    while (axi.axi_bvalid_o !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) ok = 1'b0;
    bWait = n;
    resp  = axi.axi_bresp_o;
    bid   = axi.axi_bid_o;
    @(negedge clk);
    axi.axi_bready_i = 1'b0;
  endtask

  // Drive one AR and collect len+1 beats; mode 0: rready=1, 1: periodic stalls, 2: random stalls.
  task automatic axiRead(input logic [0:0] id, input logic [23:0] addr, input logic [7:0] len,
                         input int mode, output int firstLat, output int stallErr, output bit ok);
    int n, beats;
    bit stalled, r;
    logic [31:0] pd;
    logic pl;
    logic [0:0] pi;
    ok = 1'b1;
    @(negedge clk);
    axi.axi_arid_i    = id;
    axi.axi_araddr_i  = addr;
    axi.axi_arlen_i   = len;
    axi.axi_arvalid_i = 1'b1;
    n = 0;
    while (axi.axi_arready_o !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) ok = 1'b0;
    @(negedge clk);
    axi.axi_arvalid_i = 1'b0;
    beats = 0; n = 1; firstLat = -1; stallErr = 0; stalled = 1'b0;
    pd = '0; pl = 1'b0; pi = '0;
    while (beats < int'(len) + 1 && n < TMO) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (n % 3 != 2);
        default: r = 1'($urandom_range(0, 1));
      endcase
      axi.axi_rready_i = r;
      if (axi.axi_rvalid_o === 1'b1) begin
        if (firstLat < 0) firstLat = n;
        if (stalled && (axi.axi_rdata_o !== pd || axi.axi_rlast_o !== pl || axi.axi_rid_o !== pi))
          stallErr++;
        if (r) begin
          rData[beats]  = axi.axi_rdata_o;
          rLastQ[beats] = axi.axi_rlast_o;
          rIdQ[beats]   = axi.axi_rid_o;
          rRespQ[beats] = axi.axi_rresp_o;
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd = axi.axi_rdata_o; pl = axi.axi_rlast_o; pi = axi.axi_rid_o;
        end
      end
      @(negedge clk);
      n++;
    end
    axi.axi_rready_i = 1'b0;
    if (beats != int'(len) + 1) ok = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    axi.axi_awvalid_i = 1'b1; axi.axi_arvalid_i = 1'b1;
    axi.axi_awid_i = '0; axi.axi_awaddr_i = '0; axi.axi_awlen_i = '0;
    axi.axi_arid_i = '0; axi.axi_araddr_i = '0; axi.axi_arlen_i = '0;
    axi.axi_wvalid_i = 1'b0; axi.axi_wdata_i = '0; axi.axi_wstrb_i = '0; axi.axi_wlast_i = 1'b0;
    axi.axi_bready_i = 1'b0; axi.axi_rready_i = 1'b0;
    repeat (3) @(negedge clk);
    nTotal++;
    if ({axi.axi_awready_o, axi.axi_wready_o, axi.axi_bid_o, axi.axi_bresp_o, axi.axi_bvalid_o,
         axi.axi_arready_o, axi.axi_rid_o, axi.axi_rdata_o, axi.axi_rresp_o, axi.axi_rlast_o,
         axi.axi_rvalid_o} !== '0)
      $display("[TB] FAIL reset_outputs: outputs not all zero during reset (awready=%b arready=%b rvalid=%b bvalid=%b)",
               axi.axi_awready_o, axi.axi_arready_o, axi.axi_rvalid_o, axi.axi_bvalid_o);
    else nPass++;
    axi.axi_awvalid_i = 1'b0; axi.axi_arvalid_i = 1'b0;
    axi.axi_wvalid_i = 1'b1;
    rstn = 1'b1;
    @(negedge clk);
    nTotal++;
    if ({axi.axi_arready_o, axi.axi_awready_o} !== 2'b11)
      $display("[TB] FAIL reset_release_ready: got arready/awready=%b%b, expected 11", axi.axi_arready_o, axi.axi_awready_o);
    else nPass++;
    nTotal++;
    if (axi.axi_wready_o !== 1'b0)
      $display("[TB] FAIL wready_idle: got %b, expected 0", axi.axi_wready_o);
    else nPass++;
    axi.axi_wvalid_i = 1'b0;
  endtask

  task automatic test_single();
    logic [1:0] resp; logic [0:0] bid; int bWait, lat, se; bit ok;
    wData[0] = 32'hDEADBEEF; wStrb[0] = 4'hF;
    axiWrite(1'b1, 24'h10, 8'd0, 1, 1'b0, 1'b0, resp, bid, bWait, ok);
    modelWrite(wordOf(24'h10), 32'hDEADBEEF, 4'hF);
    nTotal++; if (ok !== 1'b1) $display("[TB] FAIL single_write_done: got %b, expected 1", ok); else nPass++;
    nTotal++; if (bid !== 1'b1) $display("[TB] FAIL single_bid: got %h, expected 1", bid); else nPass++;
    nTotal++; if (resp !== 2'b00) $display("[TB] FAIL single_bresp: got %b, expected 00", resp); else nPass++;
    nTotal++; if (bWait !== 0) $display("[TB] FAIL single_b_latency: got %0d extra cycles, expected 0", bWait); else nPass++;
    axiRead(1'b1, 24'h10, 8'd0, 0, lat, se, ok);
    nTotal++; if (ok !== 1'b1) $display("[TB] FAIL single_read_done: got %b, expected 1", ok); else nPass++;
    nTotal++; if (lat !== 2) $display("[TB] FAIL single_r_latency: got %0d, expected 2", lat); else nPass++;
    nTotal++; if (rData[0] !== 32'hDEADBEEF) $display("[TB] FAIL single_rdata: got %h, expected deadbeef", rData[0]); else nPass++;
    nTotal++; if (rLastQ[0] !== 1'b1) $display("[TB] FAIL single_rlast: got %b, expected 1", rLastQ[0]); else nPass++;
    nTotal++; if (rIdQ[0] !== 1'b1) $display("[TB] FAIL single_rid: got %h, expected 1", rIdQ[0]); else nPass++;
    nTotal++; if (rRespQ[0] !== 2'b00) $display("[TB] FAIL single_rresp: got %b, expected 00", rRespQ[0]); else nPass++;
  endtask

  task automatic test_line_fill();
    logic [1:0] resp; logic [0:0] bid; int bWait, lat, se; bit ok;
    for (int i = 0; i < 8; i++) begin
      wData[i] = 32'(i); wStrb[i] = 4'hF;
      modelWrite(wordOf(24'h100) + i, 32'(i), 4'hF);
    end
    axiWrite(1'b0, 24'h100, 8'd7, 8, 1'b0, 1'b0, resp, bid, bWait, ok);
    nTotal++; if (resp !== 2'b00 || ok !== 1'b1) $display("[TB] FAIL fill_bresp: got %b ok=%b, expected 00 ok=1", resp, ok); else nPass++;
    axiRead(1'b0, 24'h100, 8'd7, 1, lat, se, ok);
    nTotal++; if (ok !== 1'b1) $display("[TB] FAIL fill_beats: burst incomplete, expected 8 beats"); else nPass++;
    nTotal++; if (se !== 0) $display("[TB] FAIL fill_stall_stable: got %0d changes while stalled, expected 0", se); else nPass++;
    for (int i = 0; i < 8; i++) begin
      nTotal++;
      if (rData[i] !== model[wordOf(24'h100) + i] || rLastQ[i] !== (i == 7))
        $display("[TB] FAIL fill_beat%0d: got data=%h last=%b, expected data=%h last=%b",
                 i, rData[i], rLastQ[i], model[wordOf(24'h100) + i], (i == 7));
      else nPass++;
    end
  endtask

  task automatic test_strobes();
    logic [1:0] resp; logic [0:0] bid; int bWait, lat, se; bit ok;
    wData[0] = 32'h11223344; wStrb[0] = 4'hF;
    axiWrite(1'b0, 24'h200, 8'd0, 1, 1'b0, 1'b0, resp, bid, bWait, ok);
    wData[0] = 32'hAABBCCDD; wStrb[0] = 4'b0101;
    axiWrite(1'b0, 24'h200, 8'd0, 1, 1'b0, 1'b0, resp, bid, bWait, ok);
    modelWrite(wordOf(24'h200), 32'h11223344, 4'hF);
    modelWrite(wordOf(24'h200), 32'hAABBCCDD, 4'b0101);
    axiRead(1'b0, 24'h200, 8'd0, 0, lat, se, ok);
    nTotal++; if (rData[0] !== 32'h11BB33DD) $display("[TB] FAIL strobe_merge: got %h, expected 11bb33dd", rData[0]); else nPass++;
  endtask

  task automatic test_wrap_and_error();
    logic [1:0] resp; logic [0:0] bid; int bWait, lat, se; bit ok;
    // burst starting at the last word wraps to word 0
    wData[0] = 32'hA5A50001; wData[1] = 32'hA5A50002; wStrb[0] = 4'hF; wStrb[1] = 4'hF;
    axiWrite(1'b0, 24'hFFC, 8'd1, 2, 1'b0, 1'b0, resp, bid, bWait, ok);
    modelWrite(1023, 32'hA5A50001, 4'hF);
    modelWrite(0, 32'hA5A50002, 4'hF);
    nTotal++; if (resp !== 2'b00) $display("[TB] FAIL wrap_bresp: got %b, expected 00", resp); else nPass++;
    axiRead(1'b0, 24'h000, 8'd0, 0, lat, se, ok);
    nTotal++; if (rData[0] !== model[0]) $display("[TB] FAIL wrap_word0: got %h, expected %h", rData[0], model[0]); else nPass++;
    axiRead(1'b0, 24'hFFC, 8'd1, 0, lat, se, ok);
    nTotal++;
    if (rData[0] !== model[1023] || rData[1] !== model[0])
      $display("[TB] FAIL wrap_read: got %h %h, expected %h %h", rData[0], rData[1], model[1023], model[0]);
    else nPass++;
    // preload three words, then end a 3-beat burst early with wlast on beat 2
    for (int i = 0; i < 3; i++) begin
      wData[i] = 32'h5000_0000 + 32'(i); wStrb[i] = 4'hF;
      modelWrite(wordOf(24'h300) + i, wData[i], 4'hF);
    end
    axiWrite(1'b0, 24'h300, 8'd2, 3, 1'b0, 1'b0, resp, bid, bWait, ok);
    wData[0] = 32'h6000_0000; wData[1] = 32'h6000_0001;
    axiWrite(1'b1, 24'h300, 8'd2, 2, 1'b0, 1'b0, resp, bid, bWait, ok);
    modelWrite(wordOf(24'h300), 32'h6000_0000, 4'hF);
    modelWrite(wordOf(24'h300) + 1, 32'h6000_0001, 4'hF);
    nTotal++; if (resp !== 2'b10 || ok !== 1'b1) $display("[TB] FAIL early_wlast_bresp: got %b ok=%b, expected 10 ok=1", resp, ok); else nPass++;
    axiRead(1'b0, 24'h300, 8'd2, 0, lat, se, ok);
    for (int i = 0; i < 3; i++) begin
      nTotal++;
      if (rData[i] !== model[wordOf(24'h300) + i])
        $display("[TB] FAIL early_wlast_word%0d: got %h, expected %h", i, rData[i], model[wordOf(24'h300) + i]);
      else nPass++;
    end
    // length exhausted without wlast: still written, but SLVERR
    wData[0] = 32'h7777_1234; wStrb[0] = 4'hF;
    axiWrite(1'b0, 24'h340, 8'd0, 1, 1'b0, 1'b1, resp, bid, bWait, ok);
    modelWrite(wordOf(24'h340), 32'h7777_1234, 4'hF);
    nTotal++; if (resp !== 2'b10 || ok !== 1'b1) $display("[TB] FAIL missing_wlast_bresp: got %b ok=%b, expected 10 ok=1", resp, ok); else nPass++;
    axiRead(1'b0, 24'h340, 8'd0, 0, lat, se, ok);
    nTotal++; if (rData[0] !== 32'h7777_1234) $display("[TB] FAIL missing_wlast_data: got %h, expected 77771234", rData[0]); else nPass++;
  endtask

  task automatic test_concurrency();
    logic [1:0] resp, resp2; logic [0:0] bid, bid2; int bWait, bWait2, lat, se; bit ok, okW, okR;
    logic [31:0] oldVal;
    wData[0] = 32'h0BADF00D; wStrb[0] = 4'hF;
    axiWrite(1'b0, 24'h400, 8'd0, 1, 1'b0, 1'b0, resp, bid, bWait, ok);
    modelWrite(wordOf(24'h400), 32'h0BADF00D, 4'hF);
    oldVal = model[wordOf(24'h400)];
    wData[0] = 32'h600DCAFE;
    fork
      axiWrite(1'b0, 24'h400, 8'd0, 1, 1'b1, 1'b0, resp2, bid2, bWait2, okW);
      axiRead(1'b1, 24'h400, 8'd0, 0, lat, se, okR);
    join
    modelWrite(wordOf(24'h400), 32'h600DCAFE, 4'hF);
    nTotal++; if (okW !== 1'b1 || resp2 !== 2'b00) $display("[TB] FAIL concurrent_write: got ok=%b bresp=%b, expected ok=1 bresp=00", okW, resp2); else nPass++;
    nTotal++; if (okR !== 1'b1 || rData[0] !== oldVal) $display("[TB] FAIL concurrent_read_old: got %h ok=%b, expected %h ok=1", rData[0], okR, oldVal); else nPass++;
    axiRead(1'b0, 24'h400, 8'd0, 0, lat, se, ok);
    nTotal++; if (rData[0] !== model[wordOf(24'h400)]) $display("[TB] FAIL concurrent_read_new: got %h, expected %h", rData[0], model[wordOf(24'h400)]); else nPass++;
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [0:0] bid; int bWait, lat, se, word, len; bit ok;
    logic [23:0] addr;
    for (int i = 0; i < 64; i++) begin
      wData[i] = $urandom; wStrb[i] = 4'hF;
      modelWrite(512 + i, wData[i], 4'hF);
    end
    axiWrite(1'b0, 24'(512 * 4), 8'd63, 64, 1'b0, 1'b0, resp, bid, bWait, ok);
    nTotal++; if (resp !== 2'b00 || ok !== 1'b1) $display("[TB] FAIL rand_init_bresp: got %b ok=%b, expected 00 ok=1", resp, ok); else nPass++;
    for (int t = 0; t < 10; t++) begin
      len  = $urandom_range(0, 7);
      word = 512 + $urandom_range(0, 63 - len);
      addr = (24'($urandom) & 24'hFFF000) | 24'(word * 4) | 24'($urandom_range(0, 3));
      for (int i = 0; i <= len; i++) begin
        wData[i] = $urandom; wStrb[i] = 4'($urandom);
        modelWrite(word + i, wData[i], wStrb[i]);
      end
      axiWrite(1'($urandom), addr, 8'(len), len + 1, 1'b0, 1'b0, resp, bid, bWait, ok);
      nTotal++; if (resp !== 2'b00 || ok !== 1'b1) $display("[TB] FAIL rand_bresp_%0d: got %b ok=%b, expected 00 ok=1", t, resp, ok); else nPass++;
      len  = $urandom_range(0, 7);
      word = 512 + $urandom_range(0, 63 - len);
      addr = (24'($urandom) & 24'hFFF000) | 24'(word * 4) | 24'($urandom_range(0, 3));
      axiRead(1'b0, addr, 8'(len), 2, lat, se, ok);
      nTotal++; if (ok !== 1'b1 || se !== 0) $display("[TB] FAIL rand_read_%0d: got ok=%b stallChanges=%0d, expected ok=1 stallChanges=0", t, ok, se); else nPass++;
      for (int i = 0; i <= len; i++) begin
        nTotal++;
        if (rData[i] !== model[word + i] || rLastQ[i] !== (i == len))
          $display("[TB] FAIL rand_beat_%0d_%0d: got data=%h last=%b, expected data=%h last=%b",
                   t, i, rData[i], rLastQ[i], model[word + i], (i == len));
        else nPass++;
      end
    end
  endtask

  task automatic test_reset_abort();
    int n, lat, se; bit ok;
    @(negedge clk);
    axi.axi_arid_i = 1'b1; axi.axi_araddr_i = 24'h100; axi.axi_arlen_i = 8'd3; axi.axi_arvalid_i = 1'b1;
    n = 0;
    while (axi.axi_arready_o !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    @(negedge clk);
    axi.axi_arvalid_i = 1'b0;
    n = 0;
    while (axi.axi_rvalid_o !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    nTotal++; if (n >= TMO) $display("[TB] FAIL abort_rvalid_timeout: no rvalid within %0d cycles", TMO); else nPass++;
    rstn = 1'b0;
    @(negedge clk);
    nTotal++;
    if ({axi.axi_rvalid_o, axi.axi_rlast_o, axi.axi_rdata_o, axi.axi_rid_o, axi.axi_arready_o} !== '0)
      $display("[TB] FAIL abort_outputs: got rvalid=%b rdata=%h arready=%b, expected all 0",
               axi.axi_rvalid_o, axi.axi_rdata_o, axi.axi_arready_o);
    else nPass++;
    rstn = 1'b1;
    @(negedge clk);
    nTotal++; if (axi.axi_arready_o !== 1'b1 || axi.axi_rvalid_o !== 1'b0) $display("[TB] FAIL abort_idle: got arready=%b rvalid=%b, expected 1 0", axi.axi_arready_o, axi.axi_rvalid_o); else nPass++;
    axiRead(1'b0, 24'h104, 8'd0, 0, lat, se, ok);
    nTotal++; if (rData[0] !== model[wordOf(24'h104)]) $display("[TB] FAIL abort_ram_kept: got %h, expected %h", rData[0], model[wordOf(24'h104)]); else nPass++;
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_single();
    test_line_fill();
    test_strobes();
    test_wrap_and_error();
    test_concurrency();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

  // Hard stop in case the DUT wedges the handshakes badly enough to stall everything.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
